// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared request-panel / controller definitions
package elevator_pkg;

  localparam int NUM_FLOORS_DEFAULT = 5;
  localparam int FLOOR_W_DEFAULT    = 3;

  // req_kind encodings; 2'd3 is never driven
  localparam logic [1:0] KIND_CAB = 2'd0;
  localparam logic [1:0] KIND_UP  = 2'd1;
  localparam logic [1:0] KIND_DN  = 2'd2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } req_state_e;

endpackage

// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - tick-sampled debouncer producing one press pulse per clean rising edge
module button_debounce #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_i,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] press_o
);

  logic [WIDTH-1:0] newer_q, newer_d;
  logic [WIDTH-1:0] older_q, older_d;

  // History only advances on the shared sample tick
  always_comb begin
    newer_d = newer_q;
    older_d = older_q;
    if (tick_i) begin
      older_d = newer_q;
      newer_d = btn_i;
    end
  end

  // Two-deep sample history; cleared so a button held through reset still registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      newer_q <= '0;
      older_q <= '0;
    end else begin
      newer_q <= newer_d;
      older_q <= older_d;
    end
  end

  // Press when the samples read 0,1 and the new one is 1: a single clean rise
  assign press_o = {WIDTH{tick_i}} & ~older_q & newer_q & btn_i;

endmodule

// File: rtl/elevator_request_panel.sv
// rtl/elevator_request_panel.sv - button latching, lamps and round-robin request stream
module elevator_request_panel
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS      = NUM_FLOORS_DEFAULT,
  parameter int FLOOR_W         = FLOOR_W_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] hall_up_btn,
  input  logic [NUM_FLOORS-1:0] hall_dn_btn,
  input  logic [NUM_FLOORS-1:0] cab_btn,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic [1:0]            req_kind,
  input  logic                  serviced_valid,
  input  logic [FLOOR_W-1:0]    serviced_floor,
  input  logic                  serviced_dir,
  output logic [NUM_FLOORS-1:0] lamp_up,
  output logic [NUM_FLOORS-1:0] lamp_dn,
  output logic [NUM_FLOORS-1:0] lamp_cab
);

  // Slots are ordered cab[0..N-1], up[0..N-1], dn[0..N-1]
  localparam int NUM_SLOTS = 3 * NUM_FLOORS;
  localparam int SLOT_W    = $clog2(NUM_SLOTS);
  localparam int CNT_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [NUM_SLOTS-1:0] ONE       = NUM_SLOTS'(1);
  localparam logic [SLOT_W:0]      NS_EXT    = (SLOT_W + 1)'(NUM_SLOTS);
  localparam logic [SLOT_W-1:0]    SLOT_LAST = SLOT_W'(NUM_SLOTS - 1);
  localparam logic [SLOT_W-1:0]    UP_BASE   = SLOT_W'(NUM_FLOORS);
  localparam logic [SLOT_W-1:0]    DN_BASE   = SLOT_W'(2 * NUM_FLOORS);

  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tick;
  logic [NUM_SLOTS-1:0] press, press_ok, new_press, svc_clr, hs_mask;
  logic [NUM_SLOTS-1:0] pending_q, pending_d, sent_q, sent_d;
  logic [NUM_SLOTS-1:0] eligible, rot;
  logic                 pick_found;
  logic [SLOT_W-1:0]    pick_off, pick_idx;
  logic [SLOT_W:0]      pick_sum;
  logic [FLOOR_W-1:0]   pick_floor;
  logic [1:0]           pick_kind;
  req_state_e           state_q, state_d;
  logic                 req_valid_q, req_valid_d;
  logic [FLOOR_W-1:0]   req_floor_q, req_floor_d;
  logic [1:0]           req_kind_q, req_kind_d;
  logic [SLOT_W-1:0]    req_idx_q, req_idx_d;
  logic [SLOT_W-1:0]    ptr_q, ptr_d;

  // Free-running sample counter; tick is high for one cycle per period
  assign tick  = (cnt_q == CNT_LAST);
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  button_debounce #(
    .WIDTH (NUM_SLOTS)
  ) u_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_i  (tick),
    .btn_i   ({hall_dn_btn, hall_up_btn, cab_btn}),
    .press_o (press)
  );

  // Top floor has no up button and bottom floor has no down button
  always_comb begin
    press_ok                   = press;
    press_ok[2*NUM_FLOORS - 1] = 1'b0;
    press_ok[2*NUM_FLOORS]     = 1'b0;
  end

  // Service clears the cab slot and the hall slot in the departing direction
  always_comb begin
    svc_clr = '0;
    if (serviced_valid && (int'(serviced_floor) < NUM_FLOORS)) begin
      svc_clr = ONE << serviced_floor;
      if (serviced_dir) begin
        svc_clr = svc_clr | (ONE << (int'(serviced_floor) + NUM_FLOORS));
      end else begin
        svc_clr = svc_clr | (ONE << (int'(serviced_floor) + 2 * NUM_FLOORS));
      end
    end
  end

  // Pending/sent bookkeeping; service is applied last so it beats a same-cycle press
  always_comb begin
    hs_mask   = (state_q == OFFER && req_ready) ? (ONE << req_idx_q) : '0;
    new_press = press_ok & ~pending_q;
    pending_d = (pending_q | press_ok) & ~svc_clr;
    sent_d    = (sent_q | (hs_mask & pending_q)) & ~new_press & ~svc_clr;
  end

  // Round-robin pick: rotate eligibility so the pointer slot lands at bit 0
  always_comb begin
    eligible   = pending_q & ~sent_q;
    rot        = NUM_SLOTS'({eligible, eligible} >> ptr_q);
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pick_found = 1'b1;
        pick_off   = SLOT_W'(i);
      end
    end
    pick_sum = {1'b0, ptr_q} + {1'b0, pick_off};
    if (pick_sum >= NS_EXT) begin
      pick_sum = pick_sum - NS_EXT;
    end
    pick_idx = pick_sum[SLOT_W-1:0];
    if (pick_idx < UP_BASE) begin
      pick_kind  = KIND_CAB;
      pick_floor = FLOOR_W'(pick_idx);
    end else if (pick_idx < DN_BASE) begin
      pick_kind  = KIND_UP;
      pick_floor = FLOOR_W'(pick_idx - UP_BASE);
    end else begin
      pick_kind  = KIND_DN;
      pick_floor = FLOOR_W'(pick_idx - DN_BASE);
    end
  end

  // Offer FSM: the offer is held until accepted, even if the slot gets serviced meanwhile
  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid_q;
    req_floor_d = req_floor_q;
    req_kind_d  = req_kind_q;
    req_idx_d   = req_idx_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d     = OFFER;
          req_valid_d = 1'b1;
          req_floor_d = pick_floor;
          req_kind_d  = pick_kind;
          req_idx_d   = pick_idx;
        end
      end
      OFFER: begin
        if (req_ready) begin
          state_d     = IDLE;
          req_valid_d = 1'b0;
          ptr_d       = (req_idx_q == SLOT_LAST) ? '0 : req_idx_q + SLOT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; asynchronous reset drops an in-flight offer immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pending_q   <= '0;
      sent_q      <= '0;
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_floor_q <= '0;
      req_kind_q  <= KIND_CAB;
      req_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      sent_q      <= sent_d;
      state_q     <= state_d;
      req_valid_q <= req_valid_d;
      req_floor_q <= req_floor_d;
      req_kind_q  <= req_kind_d;
      req_idx_q   <= req_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_floor = req_floor_q;
  assign req_kind  = req_kind_q;
  assign lamp_cab  = pending_q[NUM_FLOORS-1:0];
  assign lamp_up   = pending_q[2*NUM_FLOORS-1:NUM_FLOORS];
  assign lamp_dn   = pending_q[3*NUM_FLOORS-1:2*NUM_FLOORS];

endmodule
